// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit serializer: default widths,
// PRBS-7 idle-pattern constants and the antipodal bit-to-symbol mapping.
package bpsk_pkg;

   localparam int SYM_W_DEF = 16;
   localparam int AMP_DEF   = 8191;

   // PRBS-7, x^7 + x^6 + 1: the feedback bit is s[6] ^ s[5]
   localparam logic [6:0] PRBS7_SEED  = 7'h7F;
   localparam int         PRBS7_TAP_A = 6;
   localparam int         PRBS7_TAP_B = 5;

   // What a symbol strobe does this cycle
   typedef enum logic [1:0] {
      EMIT_NONE  = 2'd0,
      EMIT_SHIFT = 2'd1,
      EMIT_LOAD  = 2'd2,
      EMIT_IDLE  = 2'd3
   } emit_kind_t;

   // Bit 0 maps to +amp and bit 1 to -amp, returned at 32-bit signed width
   function automatic logic signed [31:0] bpsk_map(input logic b, input int amp);
      logic signed [31:0] v;
      v = amp;
      return b ? -v : v;
   endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS-7 idle-bit generator (x^7 + x^6 + 1). bit_o is the next sequence bit;
// the register steps only when adv is high.
module prbs7_gen
   import bpsk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic adv,
   output logic bit_o
);

   logic [6:0] r_state;

   assign bit_o = r_state[PRBS7_TAP_A] ^ r_state[PRBS7_TAP_B];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= PRBS7_SEED;
      end else if (adv) begin
         r_state <= {r_state[5:0], bit_o};
      end
   end

endmodule

// File: rtl/bpsk_bit_serializer.sv
// MSB-first bit serializer with a one-word holding register and BPSK symbol map.
// Define BPSK_SER_IDLE_PRBS_EN to fill underrun strobes with PRBS-7 instead of 0.
module bpsk_bit_serializer
   import bpsk_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SYM_W  = SYM_W_DEF,
   parameter int AMP    = AMP_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DATA_W-1:0]       din,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic                    bit_out,
   output logic signed [SYM_W-1:0] sym_out,
   output logic                    sym_valid,
   output logic                    underrun
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

   logic [DATA_W-1:0]  r_hold;
   logic               r_hold_full;
   logic [DATA_W-1:0]  r_sh;
   logic [CW-1:0]      r_cnt;

   emit_kind_t         w_kind;
   logic               w_accept;
   logic               w_idle_bit;
   logic               w_emit_bit;
   logic signed [31:0] w_sym_full;

   assign din_ready = ~r_hold_full;
   assign w_accept  = din_valid & ~r_hold_full;

`ifdef BPSK_SER_IDLE_PRBS_EN
   prbs7_gen u_prbs7_gen (
      .clk   (clk),
      .rst   (rst),
      .adv   (w_kind == EMIT_IDLE),
      .bit_o (w_idle_bit)
   );
`else
   assign w_idle_bit = 1'b0;
`endif

   always_comb begin
      w_kind = EMIT_NONE;
      if (en) begin
         if (r_cnt != '0) begin
            w_kind = EMIT_SHIFT;
         end else if (r_hold_full) begin
            w_kind = EMIT_LOAD;
         end else begin
            w_kind = EMIT_IDLE;
         end
      end
   end

   always_comb begin
      w_emit_bit = 1'b0;
      case (w_kind)
         EMIT_SHIFT: w_emit_bit = r_sh[DATA_W-1];
         EMIT_LOAD:  w_emit_bit = r_hold[DATA_W-1];
         EMIT_IDLE:  w_emit_bit = w_idle_bit;
         default:    w_emit_bit = 1'b0;
      endcase
   end

   assign w_sym_full = bpsk_map(w_emit_bit, AMP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_sh        <= '0;
         r_cnt       <= '0;
         bit_out     <= 1'b0;
         sym_out     <= '0;
         sym_valid   <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         sym_valid <= en;
         underrun  <= (w_kind == EMIT_IDLE);

         if (w_kind != EMIT_NONE) begin
            bit_out <= w_emit_bit;
            sym_out <= w_sym_full[SYM_W-1:0];
         end

         case (w_kind)
            EMIT_SHIFT: begin
               r_sh  <= r_sh << 1;
               r_cnt <= r_cnt - CW'(1);
            end
            EMIT_LOAD: begin
               r_sh        <= r_hold << 1;
               r_cnt       <= CNT_LAST;
               r_hold_full <= 1'b0;
            end
            default: ;
         endcase

         // Accept needs an empty hold register and a load needs a full one,
         // so the two hold_full updates never collide.
         if (w_accept) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bpsk_bit_serializer.sv
// Directed self-checking bench for bpsk_bit_serializer (DATA_W=8, SYM_W=16, AMP=8191).
module tb_bpsk_bit_serializer;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic [7:0]        din = '0;
   logic              din_valid = 1'b0;
   logic              din_ready;
   logic              bit_out;
   logic signed [15:0] sym_out;
   logic              sym_valid;
   logic              underrun;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] q_words[$];

   bpsk_bit_serializer #(.DATA_W(8), .SYM_W(16), .AMP(8191)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .bit_out   (bit_out),
      .sym_out   (sym_out),
      .sym_valid (sym_valid),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one cycle; the upstream feeder pops a word on each handshake.
   task automatic tick();
      logic hs;
      hs = din_valid && din_ready && !rst && (q_words.size() > 0);
      @(posedge clk);
      #1;
      if (hs) begin
         void'(q_words.pop_front());
         if (q_words.size() > 0) din = q_words[0];
         else din_valid = 1'b0;
      end
   endtask

   task automatic feed(input logic [7:0] w);
      q_words.push_back(w);
      din       = q_words[0];
      din_valid = 1'b1;
   endtask

   task automatic do_reset();
      q_words.delete();
      din_valid = 1'b0;
      en        = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // One strobe with en left high afterwards; caller drops en when done.
   task automatic strobe(input string tag, input logic exp_bit, input logic exp_under);
      en = 1'b1;
      tick();
      check_eq({tag, ".valid"}, int'(sym_valid), 1);
      check_eq({tag, ".bit"}, int'(bit_out), int'(exp_bit));
      check_eq({tag, ".sym"}, int'($signed(sym_out)), exp_bit ? -8191 : 8191);
      check_eq({tag, ".under"}, int'(underrun), int'(exp_under));
   endtask

   task automatic strobe_word(input string tag, input logic [7:0] w);
      for (int b = 7; b >= 0; b--) strobe($sformatf("%s.b%0d", tag, b), w[b], 1'b0);
   endtask

   initial begin
      logic [7:0] w;
      logic [6:0] idle_bits;

      // Reset with upstream valid: everything cleared, ready high
      rst = 1'b1; din = 8'h55; din_valid = 1'b1;
      tick(); tick();
      check_eq("rst.bit", int'(bit_out), 0);
      check_eq("rst.sym", int'($signed(sym_out)), 0);
      check_eq("rst.valid", int'(sym_valid), 0);
      check_eq("rst.under", int'(underrun), 0);
      check_eq("rst.ready", int'(din_ready), 1);
      din_valid = 1'b0; rst = 1'b0;
      tick();

      // Single word 0xA5, strobe every 4 cycles
      feed(8'hA5);
      tick();
      check_eq("single.ready_low", int'(din_ready), 0);
      w = 8'hA5;
      for (int b = 7; b >= 0; b--) begin
         strobe($sformatf("single.b%0d", b), w[b], 1'b0);
         en = 1'b0;
         tick();
         check_eq("single.valid_drop", int'(sym_valid), 0);
         check_eq("single.bit_hold", int'(bit_out), int'(w[b]));
         tick(); tick();
      end

      // Back-to-back 0xFF then 0x00, en every cycle
      do_reset();
      feed(8'hFF); feed(8'h00);
      tick();
      strobe("b2b.ff.b7", 1'b1, 1'b0);
      check_eq("b2b.ready_after_load", int'(din_ready), 1);
      strobe("b2b.ff.b6", 1'b1, 1'b0);
      check_eq("b2b.ready_after_accept", int'(din_ready), 0);
      for (int b = 5; b >= 0; b--) strobe($sformatf("b2b.ff.b%0d", b), 1'b1, 1'b0);
      strobe_word("b2b.00", 8'h00);
      strobe("b2b.s17", 1'b0, 1'b1);
      en = 1'b0;
      tick();

      // Underrun: 7 strobes with no data
      do_reset();
`ifdef BPSK_SER_IDLE_PRBS_EN
      idle_bits = 7'b0000001;
`else
      idle_bits = 7'b0000000;
`endif
      for (int i = 6; i >= 0; i--) begin
         strobe($sformatf("under.%0d", 6 - i), idle_bits[i], 1'b1);
         en = 1'b0;
         tick();
      end

      // Backpressure: 0x0F loaded, 0xF0 in hold, 0x3C waits upstream
      do_reset();
      feed(8'h0F); feed(8'hF0); feed(8'h3C);
      tick();
      strobe("bp.0f.b7", 1'b0, 1'b0);
      en = 1'b0;
      tick();
      check_eq("bp.ready_full", int'(din_ready), 0);
      tick(); tick();
      check_eq("bp.ready_still_low", int'(din_ready), 0);
      check_eq("bp.din_waiting", int'(din), 8'h3C);
      w = 8'h0F;
      for (int b = 6; b >= 0; b--) strobe($sformatf("bp.0f.b%0d", b), w[b], 1'b0);
      check_eq("bp.ready_before_f0", int'(din_ready), 0);
      strobe_word("bp.f0", 8'hF0);
      strobe_word("bp.3c", 8'h3C);
      en = 1'b0;
      tick();

      // Reset mid-word: 0xC3 interrupted after 3 bits, then 0x81
      do_reset();
      feed(8'hC3);
      tick();
      strobe("mid.c3.b7", 1'b1, 1'b0);
      strobe("mid.c3.b6", 1'b1, 1'b0);
      strobe("mid.c3.b5", 1'b0, 1'b0);
      en = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("mid.rst_bit", int'(bit_out), 0);
      check_eq("mid.rst_sym", int'($signed(sym_out)), 0);
      check_eq("mid.rst_ready", int'(din_ready), 1);
      tick();
      rst = 1'b0;
      tick();
      feed(8'h81);
      tick();
      strobe_word("mid.81", 8'h81);
      strobe("mid.after", 1'b0, 1'b1);
      en = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
